// File: rtl/vidout_pkg.sv
// vidout_pkg: selector state type and default timing constants for vidout_select.
// The BLANK state exists only when VIDOUT_BLANK_EN is defined.
package vidout_pkg;

`ifdef VIDOUT_BLANK_EN
    typedef enum logic [1:0] {ST_RUN, ST_WAIT_VS, ST_BLANK} vid_state_t;
`else
    typedef enum logic [1:0] {ST_RUN, ST_WAIT_VS} vid_state_t;
`endif

    localparam logic [15:0] DEF_DEBOUNCE_CYC = 16'd50000;
    localparam logic [3:0]  DEF_BLANK_FRAMES = 4'd2;
    localparam logic [23:0] DEF_VS_TIMEOUT   = 24'd1000000;

endpackage

// File: rtl/vidout_debounce.sv
// vidout_debounce: 2-flop synchroniser plus stability counter for the source request.
// clean takes a new value only after CYC consecutive identical synchronised samples.
module vidout_debounce
    import vidout_pkg::*;
#(
    parameter int unsigned    W    = 3,
    parameter logic [15:0]    CYC  = DEF_DEBOUNCE_CYC,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic         clk,
    input  logic         reset_l,
    input  logic [W-1:0] raw,
    output logic [W-1:0] clean
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] cand;
    logic [15:0]  cnt;

    // cnt holds how many consecutive samples have matched cand
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sync1 <= INIT;
            sync2 <= INIT;
            cand  <= INIT;
            clean <= INIT;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= 16'd1;
            end else if (cand == clean) begin
                cnt <= '0;
            end else if (cnt >= CYC - 16'd1) begin
                clean <= cand;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/vidout_select.sv
// vidout_select: debounced, vsync-aligned video source selector with registered outputs.
// Define VIDOUT_BLANK_EN to blank RGB/de for BLANK_FRAMES new-source frames after a switch.
module vidout_select
    import vidout_pkg::*;
#(
    parameter int unsigned N_SRC        = 2,
    parameter int unsigned SEL_W        = 3,
    parameter int unsigned RED_W        = 6,
    parameter int unsigned GRN_W        = 7,
    parameter int unsigned BLU_W        = 6,
    parameter int unsigned INIT_SRC     = 0,
    parameter logic [15:0] DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter logic [3:0]  BLANK_FRAMES = DEF_BLANK_FRAMES,
    parameter logic [23:0] VS_TIMEOUT   = DEF_VS_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic [N_SRC*RED_W-1:0]   src_red,
    input  logic [N_SRC*GRN_W-1:0]   src_green,
    input  logic [N_SRC*BLU_W-1:0]   src_blue,
    input  logic [N_SRC-1:0]         src_hsync,
    input  logic [N_SRC-1:0]         src_vsync,
    input  logic [N_SRC-1:0]         src_de,
    input  logic [SEL_W-1:0]         sel_req,
    output logic [RED_W-1:0]         red,
    output logic [GRN_W-1:0]         green,
    output logic [BLU_W-1:0]         blue,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     de,
    output logic [SEL_W-1:0]         active_src,
    output logic                     switching
);

    if (N_SRC < 2 || N_SRC > 8 || BLANK_FRAMES == 4'd0) begin : g_param_check
        $error("vidout_select: N_SRC or BLANK_FRAMES out of range");
    end

    logic [SEL_W-1:0] req;
    logic [SEL_W-1:0] pending;
    vid_state_t       state;
    logic [23:0]      to_cnt;
    logic             vs_q;
    logic [RED_W-1:0] sel_red;
    logic [GRN_W-1:0] sel_green;
    logic [BLU_W-1:0] sel_blue;
    logic             sel_hs;
    logic             sel_vs;
    logic             sel_de;
    logic             vs_rise;
    logic             req_valid;
    logic             timeout;
    logic             blank;

    vidout_debounce #(
        .W    (SEL_W),
        .CYC  (DEBOUNCE_CYC),
        .INIT (SEL_W'(INIT_SRC))
    ) u_debounce (
        .clk     (clk),
        .reset_l (reset_l),
        .raw     (sel_req),
        .clean   (req)
    );

    always_comb begin
        sel_red   = '0;
        sel_green = '0;
        sel_blue  = '0;
        sel_hs    = 1'b0;
        sel_vs    = 1'b0;
        sel_de    = 1'b0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (active_src == SEL_W'(k)) begin
                sel_red   = src_red[k*RED_W +: RED_W];
                sel_green = src_green[k*GRN_W +: GRN_W];
                sel_blue  = src_blue[k*BLU_W +: BLU_W];
                sel_hs    = src_hsync[k];
                sel_vs    = src_vsync[k];
                sel_de    = src_de[k];
            end
        end
    end

    assign vs_rise   = sel_vs & ~vs_q;
    assign req_valid = 32'(req) < N_SRC;
    assign timeout   = (to_cnt == VS_TIMEOUT);
    assign switching = (state != ST_RUN);

`ifdef VIDOUT_BLANK_EN
    logic [3:0] frame_cnt;
    assign blank = (state == ST_BLANK);
`else
    assign blank = 1'b0;
`endif

    // vs_q tracks whichever source is active, so after a switch edges are taken from the new source
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state      <= ST_RUN;
            active_src <= SEL_W'(INIT_SRC);
            pending    <= SEL_W'(INIT_SRC);
            to_cnt     <= '0;
            vs_q       <= 1'b0;
`ifdef VIDOUT_BLANK_EN
            frame_cnt  <= '0;
`endif
        end else begin
            vs_q <= sel_vs;
            case (state)
                ST_RUN: begin
                    if (req_valid && req != active_src) begin
                        pending <= req;
                        to_cnt  <= '0;
                        state   <= ST_WAIT_VS;
                    end
                end
                ST_WAIT_VS: begin
                    if (req == active_src) begin
                        state <= ST_RUN;
                    end else begin
                        if (!timeout) to_cnt <= to_cnt + 24'd1;
                        if (vs_rise || timeout) begin
                            active_src <= req_valid ? req : pending;
`ifdef VIDOUT_BLANK_EN
                            frame_cnt  <= BLANK_FRAMES;
                            state      <= ST_BLANK;
`else
                            state      <= ST_RUN;
`endif
                        end else if (req_valid) begin
                            pending <= req;
                        end
                    end
                end
`ifdef VIDOUT_BLANK_EN
                ST_BLANK: begin
                    if (vs_rise) begin
                        frame_cnt <= frame_cnt - 4'd1;
                        if (frame_cnt == 4'd1) state <= ST_RUN;
                    end
                end
`endif
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hsync <= 1'b0;
            vsync <= 1'b0;
            de    <= 1'b0;
        end else begin
            hsync <= sel_hs;
            vsync <= sel_vs;
            if (blank) begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
                de    <= 1'b0;
            end else begin
                red   <= sel_red;
                green <= sel_green;
                blue  <= sel_blue;
                de    <= sel_de;
            end
        end
    end

endmodule

// File: tb/tb_vidout_select.sv
// tb_vidout_select: directed phases with random video data, checked every cycle against a
// behavioural model of the selector rules. Honours VIDOUT_BLANK_EN like the design.
module tb_vidout_select;

    localparam int unsigned N   = 2;
    localparam int unsigned SW  = 3;
    localparam int unsigned RW  = 6;
    localparam int unsigned GW  = 7;
    localparam int unsigned BW  = 6;
    localparam int unsigned CYC = 10;
    localparam int unsigned BF  = 2;
    localparam int unsigned TO  = 100;
`ifdef VIDOUT_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_l = 1'b0;
    logic [N*RW-1:0] src_red;
    logic [N*GW-1:0] src_green;
    logic [N*BW-1:0] src_blue;
    logic [N-1:0]    src_hsync;
    logic [N-1:0]    src_vsync;
    logic [N-1:0]    src_de;
    logic [SW-1:0]   sel_req = '0;
    logic [RW-1:0]   red;
    logic [GW-1:0]   green;
    logic [BW-1:0]   blue;
    logic            hsync;
    logic            vsync;
    logic            de;
    logic [SW-1:0]   active_src;
    logic            switching;

    vidout_select #(
        .N_SRC        (N),
        .SEL_W        (SW),
        .RED_W        (RW),
        .GRN_W        (GW),
        .BLU_W        (BW),
        .INIT_SRC     (0),
        .DEBOUNCE_CYC (16'd10),
        .BLANK_FRAMES (4'd2),
        .VS_TIMEOUT   (24'd100)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .src_red    (src_red),
        .src_green  (src_green),
        .src_blue   (src_blue),
        .src_hsync  (src_hsync),
        .src_vsync  (src_vsync),
        .src_de     (src_de),
        .sel_req    (sel_req),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .active_src (active_src),
        .switching  (switching)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // model: 0 = running, 1 = waiting for vsync, 2 = blanking
    int  m_req, m_state, m_act, m_pend, m_frames, m_to;
    bit  m_vsq;
    int  hist[$];
    logic [RW-1:0] e_red;
    logic [GW-1:0] e_green;
    logic [BW-1:0] e_blue;
    logic e_hs, e_vs, e_de;

    int cyc = 0;
    bit vs_hold[N];
    int per[N] = '{37, 53};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_state = 0; m_act = 0; m_pend = 0; m_frames = 0; m_to = 0;
        m_vsq = 1'b0;
        hist.delete();
        for (int i = 0; i < int'(CYC) + 2; i++) hist.push_back(0);
        e_red = '0; e_green = '0; e_blue = '0;
        e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0;
    endtask

    // advances the model by one clock edge using the input values present before the edge
    task automatic model_edge();
        int  a;
        int  v;
        bit  rise;
        bit  stable;
        if (!reset_l) begin
            model_reset();
            return;
        end
        a    = m_act;
        e_hs = src_hsync[a];
        e_vs = src_vsync[a];
        if (m_state == 2) begin
            e_red = '0; e_green = '0; e_blue = '0; e_de = 1'b0;
        end else begin
            e_red   = src_red[a*RW +: RW];
            e_green = src_green[a*GW +: GW];
            e_blue  = src_blue[a*BW +: BW];
            e_de    = src_de[a];
        end
        rise = src_vsync[a] && !m_vsq;
        case (m_state)
            0: if (m_req < int'(N) && m_req != m_act) begin
                m_pend = m_req; m_to = 0; m_state = 1;
            end
            1: if (m_req == m_act) m_state = 0;
            else begin
                if (m_req < int'(N)) m_pend = m_req;
                if (rise || m_to == int'(TO)) begin
                    m_act = m_pend;
                    m_frames = BF;
                    m_state = BLANK_EN ? 2 : 0;
                end else begin
                    m_to++;
                end
            end
            default: if (rise) begin
                m_frames--;
                if (m_frames == 0) m_state = 0;
            end
        endcase
        m_vsq = src_vsync[a];
        // request is accepted when the last CYC synchronised samples (2 edges old) agree
        hist.push_back(int'(sel_req));
        if (hist.size() > int'(CYC) + 2) void'(hist.pop_front());
        v = hist[hist.size() - 3];
        stable = 1'b1;
        for (int k = 0; k < int'(CYC); k++)
            if (hist[hist.size() - 3 - k] != v) stable = 1'b0;
        if (stable && v != m_req) m_req = v;
    endtask

    task automatic chk_all();
        chk("red", 32'(red), 32'(e_red));
        chk("green", 32'(green), 32'(e_green));
        chk("blue", 32'(blue), 32'(e_blue));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("active_src", 32'(active_src), 32'(m_act));
        chk("switching", 32'(switching), 32'(m_state != 0));
    endtask

    task automatic drive();
        src_red   = N*RW'($urandom);
        src_green = N*GW'($urandom);
        src_blue  = N*BW'($urandom);
        src_hsync = N'($urandom);
        src_de    = N'($urandom);
        for (int k = 0; k < int'(N); k++)
            src_vsync[k] = vs_hold[k] ? 1'b0 : ((cyc % per[k]) < 3);
        cyc++;
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge();
        #1;
        chk_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // called just after a compare; pulls reset low mid-cycle and checks the asynchronous clear
    task automatic reset_mid();
        #2 reset_l = 1'b0;
        #1;
        chk("async_red", 32'(red), 32'd0);
        chk("async_de", 32'(de), 32'd0);
        chk("async_vsync", 32'(vsync), 32'd0);
        chk("async_active", 32'(active_src), 32'd0);
        chk("async_switching", 32'(switching), 32'd0);
        model_reset();
        steps(3);
        #1 reset_l = 1'b1;
    endtask

    initial begin
        vs_hold[0] = 1'b0;
        vs_hold[1] = 1'b0;
        model_reset();

        // reset state, then source 0 passes through
        steps(3);
        #1 reset_l = 1'b1;
        steps(8);

        // request for source 1 lasting one cycle short of the debounce window
        sel_req = 3'd1;
        steps(int'(CYC) - 1);
        sel_req = 3'd0;
        steps(30);
        chk("short_req_no_switch", 32'(switching), 32'd0);

        // held request switches on the source-0 vsync edge
        sel_req = 3'd1;
        steps(300);
        chk("switch_to_1", 32'(active_src), 32'd1);

        sel_req = 3'd0;
        steps(300);
        chk("switch_to_0", 32'(active_src), 32'd0);

        // no vsync from the old source: timeout forces the switch
        vs_hold[0] = 1'b1;
        sel_req = 3'd1;
        steps(320);
        chk("timeout_switch", 32'(active_src), 32'd1);
        vs_hold[0] = 1'b0;

        // out-of-range request is ignored
        sel_req = 3'd5;
        steps(40);
        chk("invalid_req_src", 32'(active_src), 32'd1);
        chk("invalid_req_idle", 32'(switching), 32'd0);

        // request withdrawn while waiting for vsync
        vs_hold[1] = 1'b1;
        sel_req = 3'd0;
        steps(16);
        chk("withdraw_wait", 32'(switching), 32'd1);
        sel_req = 3'd1;
        steps(20);
        chk("withdraw_back", 32'(switching), 32'd0);
        chk("withdraw_src", 32'(active_src), 32'd1);
        vs_hold[1] = 1'b0;

        // reset in the middle of a switch
        sel_req = 3'd0;
        for (int i = 0; i < 400 && m_state != (BLANK_EN ? 2 : 1); i++) step();
        chk("reach_switch", 32'(switching), 32'd1);
        reset_mid();
        steps(10);

        // random requests, including invalid ones and occasional stalled vsync
        for (int i = 0; i < 60; i++) begin
            sel_req = SW'($urandom_range(0, 3));
            vs_hold[0] = ($urandom_range(0, 7) == 0);
            vs_hold[1] = ($urandom_range(0, 7) == 0);
            steps(int'($urandom_range(5, 40)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vidout_select.md
# vidout_select

Parametrised, glitch-managed video output selector for the Graphics Gremlin output stage. It sits between the display cores (CGA RGBI DAC path, composite path, MDA path) and the analog/HDMI pins. It replaces the fixed combinational RGB/composite mux with a selector that:
- accepts N_SRC sources;
- debounces the config-switch request;
- changes source only on a vertical-sync boundary;
- blanks the output for a programmable number of frames so the monitor can resync.

## Interface
Parameters:
- N_SRC, 2, number of video sources (2..8)
- SEL_W, 3, width of the select request
- RED_W / GRN_W / BLU_W, 6 / 7 / 6, DAC channel widths
- INIT_SRC, 0, source active out of reset
- DEBOUNCE_CYC, 16'd50000, cycles a request must be stable before it is accepted
- BLANK_FRAMES, 2, frames blanked after a switch (1..15)
- VS_TIMEOUT, 24'd1000000, cycles to wait for a vsync edge before forcing the switch

Ports:
- clk  in  1  pixel/main clock
- reset_l  in  1  asynchronous, active-low reset
- src_red  in  N_SRC*RED_W  packed per-source red; source k occupies [k*RED_W +: RED_W]
- src_green  in  N_SRC*GRN_W  packed green
- src_blue  in  N_SRC*BLU_W  packed blue
- src_hsync / src_vsync / src_de  in  N_SRC  per-source syncs and display enable (active high, clk domain)
- sel_req  in  SEL_W  raw switch-derived source request (asynchronous)
- red / green / blue  out  RED_W / GRN_W / BLU_W  selected video
- hsync / vsync / de  out  1  selected syncs and enable
- active_src  out  SEL_W  currently selected source
- switching  out  1  high while a switch is pending or blanking

## Operation
- sel_req passes through a 2-flop synchroniser, then a debounce counter.
  - The accepted request (`req`) updates only after DEBOUNCE_CYC consecutive identical synchronised samples.
  - Any change in the sample restarts the count.
- A `req` value >= N_SRC is ignored; no state change occurs.
- State machine (states RUN, WAIT_VS, BLANK):
  - RUN: output follows active_src. If `req` != active_src, capture pending = `req` and go to WAIT_VS.
  - WAIT_VS: output still follows the old source.
    - If `req` changes to another valid source, pending updates.
    - If `req` returns to active_src, go back to RUN.
    - On a rising edge of the old source's vsync, or when the timeout counter reaches VS_TIMEOUT: active_src = pending, frame counter = BLANK_FRAMES, go to BLANK.
  - BLANK: RGB forced to 0 and de forced to 0. hsync/vsync come from the new source.
    - Each rising edge of the new vsync decrements the frame counter; at 0, go to RUN.
    - A new request arriving during BLANK is acted on only after returning to RUN.
- vsync edge detection uses a registered copy of the selected src_vsync.
- switching = (state != RUN).
- Channel widths are taken as-is; no truncation or extension inside the block.

## Timing
- All outputs are registered: 1-cycle latency from the src_* inputs to the outputs. The syncs and video of the same source stay aligned.
- Reset values:
  - active_src = INIT_SRC; state RUN; switching 0.
  - red/green/blue = 0; hsync = vsync = de = 0.
  - debounce and timeout counters = 0; `req` = INIT_SRC.
- Request latency: 2 sync cycles + DEBOUNCE_CYC cycles to `req`, +1 cycle to enter WAIT_VS.
- Switch instant: the cycle after the vsync rising edge is detected, the outputs carry the new source's syncs with blanked RGB.
- The timeout counter clears on entry to WAIT_VS and saturates.
- Reset asserted mid-switch returns everything to the reset values immediately (asynchronously).

## Configuration
- VIDOUT_BLANK_EN defined: the BLANK state is present and behaves as above.
- VIDOUT_BLANK_EN undefined: the BLANK state and frame counter are omitted. WAIT_VS goes directly to RUN on the switch instant, and the new source's video appears on the next cycle.
- BLANK_FRAMES is ignored when the macro is undefined.

## Structure
- Package vidout_pkg holds:
  - the state enum (RUN, WAIT_VS, BLANK);
  - default constants for DEBOUNCE_CYC, BLANK_FRAMES and VS_TIMEOUT.
- Sub-module vidout_debounce contains the synchroniser and debounce counter. Its interface is `clk`, `reset_l`, raw input, debounced output, parametrised by width and cycle count.
- The top-level instantiates one vidout_select in place of the fixed composite/RGB mux.

## Test plan
- Reset with INIT_SRC=0: all outputs 0 and active_src=0. After release, source 0 video appears on the outputs 1 cycle later.
- sel_req toggles 0→1 for DEBOUNCE_CYC−1 cycles, then back to 0: no WAIT_VS entry and switching stays 0.
- sel_req held at 1 (DEBOUNCE_CYC=10, BLANK_FRAMES=2), then a source-0 vsync edge: active_src=1, RGB/de held 0 for 2 source-1 vsync edges, then source-1 RGB appears and switching drops.
- Request for source 1 while source 0 vsync is held low: the switch is forced after VS_TIMEOUT cycles (set to 100).
- sel_req=5 with N_SRC=2: no state change.
- In WAIT_VS, request returns to 0: back to RUN without any blank output.
- Built without VIDOUT_BLANK_EN: source-1 RGB appears the cycle after the vsync edge.
- Reset asserted during BLANK: immediate return to INIT_SRC with zeroed outputs.
